mem_access_stage: RTL and testbench
===================================

// Module: mem_access_stage
// PURPOSE
//  MEM pipeline stage. Consumes the Execute stage's ALU result (data_out) as the address or passthrough value,
//  and rt as store data.
//  Runs a variable-latency request/grant/response handshake to data memory for LW/LB/LBU/SW/SB.
//  Aligns load bytes, and returns the writeback value with a valid pulse.
//  Holds the upstream pipeline via stall while an access is outstanding.
// PARAMETERS
//  TIMEOUT_CYCLES  64  cycles spent in REQ+RESP before the access is aborted with mem_err
//  CNT_W           7   width of the timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES
// PORTS
//  clock        in   1   single clock, rising edge
//  reset        in   1   asynchronous, active-high
//  valid_mem    in   1   insn/alu_result/store_data are valid this cycle
//  insn         in   32  instruction word; opcode = insn[0:5]
//  alu_result   in   32  Execute data_out: effective address for memory ops, result otherwise
//  store_data   in   32  rt value for SW/SB
//  stall        out  1   upstream must hold its inputs this cycle
//  wb_data      out  32  writeback value
//  wb_valid     out  1   one-cycle pulse: wb_data valid
//  mem_err      out  1   one-cycle pulse: misaligned LW/SW, or timeout
//  dmem_req     out  1   request valid
//  dmem_we      out  1   1 = store
//  dmem_addr    out  32  word address: alu_result with bits [30:31] forced to 0
//  dmem_be      out  4   byte enables; be[0] selects bits [0:7] (big-endian)
//  dmem_wdata   out  32  store data, replicated into the selected lane for SB
//  dmem_gnt     in   1   memory accepted the request this cycle
//  dmem_rvalid  in   1   read data valid
//  dmem_rdata   in   32  read data
// BEHAVIOUR
//  Reset values: state=IDLE; every output 0; counter 0. Reset mid-access aborts with no wb_valid or mem_err.
//   A late dmem_rvalid after reset is ignored.
//  Memory ops by opcode: LW 100011, LB 100000, LBU 100100, SW 101011, SB 101000. Any other opcode is non-mem.
//  Non-mem with valid_mem: wb_data<=alu_result, wb_valid<=1 at the next edge. Latency 1. stall=0. No bus activity.
//  Misaligned LW/SW (alu_result[30:31]!=0): no request. Next edge gives mem_err=1, and wb_valid=1 with wb_data=0 for LW.
//  Byte lane: b=alu_result[30:31]; b=0 selects bits [0:7], b=3 selects bits [24:31]. dmem_be is one-hot at index b.
//   SB: wdata = {4{store_data[24:31]}}. Word ops: be=4'b1111.
//  FSM states IDLE, REQ, RESP:
//   IDLE: on valid_mem & aligned mem op, latch addr/we/be/wdata/op/lane, then go to REQ.
//   REQ: dmem_req=1, and all dmem_* stay stable until dmem_gnt.
//    On gnt with a store: complete, go to IDLE. Stores produce no wb_valid.
//    On gnt with a load: go to RESP.
//   RESP: dmem_rvalid is sampled only here, so its earliest legal cycle is the one after gnt.
//    On rvalid: LW wb_data=rdata. LB sign-extends the lane. LBU zero-extends it.
//    Then wb_valid pulses and the FSM goes to IDLE.
//  stall = (IDLE & valid_mem & aligned mem op) | (REQ & ~(gnt & we)) | (RESP & ~rvalid & ~timeout).
//   stall drops in the completing cycle, so upstream advances at that edge. Back-to-back mem ops start directly from IDLE.
//  Timeout: counter clears on entering REQ and increments each cycle in REQ/RESP.
//   At count==TIMEOUT_CYCLES-1: drop dmem_req, pulse mem_err; a load also gets wb_valid with wb_data=0; go to IDLE.
//  gnt and timeout in the same cycle: gnt wins. rvalid and timeout in the same cycle: rvalid wins.
//  valid_mem low in IDLE: nothing happens, no pulses.
// STRUCTURE
//  Shared include mem_ops.vh: opcode constants (OP_LW, OP_LB, OP_LBU, OP_SW, OP_SB) and FSM state encodings.
//   The Execute/decode stages use the same include.
//  One sub-module, load_align: combinational (rdata, lane, signed) -> 32-bit result. The FSM and timeout live in the parent.
// TESTING
//  ADD passthrough: alu_result=32'h0000_1234, valid_mem=1 -> next cycle wb_valid=1, wb_data=32'h0000_1234, dmem_req never high.
//  LW addr 0x100, gnt after 2 cycles, rvalid 3 cycles later with rdata=0xCAFEF00D.
//   Expect: stall high throughout, dmem_addr=0x100, be=4'hF, wb_data=0xCAFEF00D one cycle after rvalid.
//  LB/LBU addr 0x103, rdata=0x000000F0 -> LB gives 0xFFFFFFF0, LBU gives 0x000000F0.
//  SB addr 0x101, store_data=0x000000AB -> be=4'b0100, wdata=0xABABABAB, completes on gnt with no wb_valid.
//  LW addr 0x102 -> no dmem_req, mem_err pulse, wb_data=0. LW with no gnt -> mem_err after 64 cycles, FSM back in IDLE.
//  Reset asserted in RESP -> outputs 0 immediately. A later rvalid produces no wb_valid. The next LW completes normally.

Source files
------------

// File: rtl/mem_access_stage_pkg.sv
// Shared MEM-stage definitions: memory opcodes, FSM states and opcode classification.
// Big-endian bit i of a W-bit bus maps to index [W-1-i] throughout.
package mem_access_stage_pkg;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SB  = 6'b101000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LB) || (op == OP_LBU) ||
           (op == OP_SW) || (op == OP_SB);
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Selects one byte lane of a loaded word and sign- or zero-extends it.
// Lane 0 is the most significant byte (big-endian).
module load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic        is_signed,
  output logic [31:0] result
);

  logic [7:0] lane_byte;

  always_comb begin
    lane_byte = rdata[31:24];
    case (lane)
      2'd0:    lane_byte = rdata[31:24];
      2'd1:    lane_byte = rdata[23:16];
      2'd2:    lane_byte = rdata[15:8];
      default: lane_byte = rdata[7:0];
    endcase
    result = {{24{is_signed & lane_byte[7]}}, lane_byte};
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: request/grant/response data-memory handshake for LW/LB/LBU/SW/SB,
// load byte alignment, writeback pulse, upstream stall and access timeout.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int CNT_W          = 7
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_mem,
  input  logic [31:0] insn,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  output logic        stall,
  output logic [31:0] wb_data,
  output logic        wb_valid,
  output logic        mem_err,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q;
  logic [5:0]       opcode;
  logic             is_mem, is_load_op, is_word_op, misaligned, start, timeout;
  logic             signed_q, word_q;
  logic [1:0]       lane_q;
  logic [31:0]      aligned;

  assign opcode     = insn[31:26];
  assign is_mem     = is_mem_op(opcode);
  assign is_load_op = (opcode == OP_LW) || (opcode == OP_LB) || (opcode == OP_LBU);
  assign is_word_op = (opcode == OP_LW) || (opcode == OP_SW);
  assign misaligned = is_word_op && (alu_result[1:0] != 2'b00);
  assign start      = valid_mem && is_mem && !misaligned;
  assign timeout    = (count_q == CNT_W'(TIMEOUT_CYCLES - 1));

  load_align u_load_align (
    .rdata     (dmem_rdata),
    .lane      (lane_q),
    .is_signed (signed_q),
    .result    (aligned)
  );

  // Stall is forced low during reset so every output reads zero while it is held.
  always_comb begin
    state_d  = state_q;
    stall    = 1'b0;
    dmem_req = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          stall   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        dmem_req = 1'b1;
        stall    = !(dmem_gnt && dmem_we);
        if (dmem_gnt)     state_d = dmem_we ? IDLE : RESP;
        else if (timeout) state_d = IDLE;
      end
      RESP: begin
        stall = !dmem_rvalid && !timeout;
        if (dmem_rvalid || timeout) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (reset) stall = 1'b0;
  end

  // Timeout counter restarts on every entry to REQ because IDLE always clears it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= (state_q == IDLE) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wb_data    <= '0;
      wb_valid   <= 1'b0;
      mem_err    <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      signed_q   <= 1'b0;
      word_q     <= 1'b0;
      lane_q     <= '0;
    end else begin
      wb_valid <= 1'b0;
      mem_err  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (valid_mem) begin
            if (!is_mem) begin
              wb_data  <= alu_result;
              wb_valid <= 1'b1;
            end else if (misaligned) begin
              mem_err <= 1'b1;
              if (is_load_op) begin
                wb_valid <= 1'b1;
                wb_data  <= '0;
              end
            end else begin
              dmem_addr  <= {alu_result[31:2], 2'b00};
              dmem_we    <= !is_load_op;
              dmem_be    <= is_word_op ? 4'b1111 : (4'b1000 >> alu_result[1:0]);
              dmem_wdata <= is_word_op ? store_data : {4{store_data[7:0]}};
              signed_q   <= (opcode == OP_LB);
              word_q     <= is_word_op;
              lane_q     <= alu_result[1:0];
            end
          end
        end
        REQ: begin
          if (!dmem_gnt && timeout) begin
            mem_err <= 1'b1;
            if (!dmem_we) begin
              wb_valid <= 1'b1;
              wb_data  <= '0;
            end
          end
        end
        RESP: begin
          if (dmem_rvalid) begin
            wb_data  <= word_q ? dmem_rdata : aligned;
            wb_valid <= 1'b1;
          end else if (timeout) begin
            mem_err  <= 1'b1;
            wb_valid <= 1'b1;
            wb_data  <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized bench for mem_access_stage: a reference model derives bus values, stall
// and writeback results from the opcode/address/handshake timing of each access.
module tb_mem_access_stage;

  localparam int T = 64;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] LB  = 6'b100000;
  localparam logic [5:0] LBU = 6'b100100;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] SB  = 6'b101000;

  logic        clock = 1'b0;
  logic        reset;
  logic        valid_mem;
  logic [31:0] insn, alu_result, store_data;
  logic        stall, wb_valid, mem_err, dmem_req, dmem_we;
  logic [31:0] wb_data, dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_gnt, dmem_rvalid;
  logic [31:0] dmem_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [5:0] mem_ops [5] = '{LW, LB, LBU, SW, SB};

  always #5 clock = ~clock;

  mem_access_stage #(.TIMEOUT_CYCLES(T), .CNT_W(7)) dut (
    .clock       (clock),
    .reset       (reset),
    .valid_mem   (valid_mem),
    .insn        (insn),
    .alu_result  (alu_result),
    .store_data  (store_data),
    .stall       (stall),
    .wb_data     (wb_data),
    .wb_valid    (wb_valid),
    .mem_err     (mem_err),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .dmem_addr   (dmem_addr),
    .dmem_be     (dmem_be),
    .dmem_wdata  (dmem_wdata),
    .dmem_gnt    (dmem_gnt),
    .dmem_rvalid (dmem_rvalid),
    .dmem_rdata  (dmem_rdata)
  );

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [31:0] model_load(input logic [5:0] op, input int lane, input logic [31:0] rdata);
    logic [31:0] b;
    b = (rdata >> (8 * (3 - lane))) & 32'hFF;
    if (op == LW) return rdata;
    if (op == LB && b >= 32'd128) return b - 32'd256;
    return b;
  endfunction

  function automatic bit is_mem(input logic [5:0] op);
    return op == LW || op == LB || op == LBU || op == SW || op == SB;
  endfunction

  // One complete aligned access; assumes it is entered at a negedge with the DUT idle.
  task automatic run_access(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [31:0] rdata, input int gnt_wait, input int rv_wait,
                            input string name);
    bit          is_load, gave_gnt, done, timed_out, give, exp_stall;
    logic [31:0] exp_addr, exp_wdata, exp_wb;
    logic [3:0]  exp_be;
    int          elapsed, lane;
    is_load   = (op == LW) || (op == LB) || (op == LBU);
    lane      = addr % 4;
    exp_addr  = addr - 32'(lane);
    exp_be    = (op == LW || op == SW) ? 4'hF : 4'(8 >> lane);
    exp_wdata = (op == SB) ? (sdata & 32'hFF) * 32'h0101_0101 : sdata;
    exp_wb    = model_load(op, lane, rdata);
    valid_mem  = 1'b1;
    insn       = {op, 26'($urandom)};
    alu_result = addr;
    store_data = sdata;
    #1;
    n_checks++;
    if (stall !== 1'b1 || dmem_req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL %s start: stall=%b req=%b, want stall=1 req=0", name, stall, dmem_req);
    end
    @(negedge clock);
    elapsed = 0; gave_gnt = 0; done = 0; timed_out = 0;
    while (!done) begin
      if (!gave_gnt) begin
        n_checks++;
        if (dmem_req !== 1'b1 || dmem_we !== !is_load || dmem_addr !== exp_addr ||
            dmem_be !== exp_be || (!is_load && dmem_wdata !== exp_wdata)) begin
          n_fail++;
          $display("[TB] FAIL %s bus c%0d: req=%b we=%b addr=%h be=%b wdata=%h, want req=1 we=%b addr=%h be=%b wdata=%h",
                   name, elapsed, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
                   !is_load, exp_addr, exp_be, exp_wdata);
        end
        give      = (elapsed == gnt_wait);
        dmem_gnt  = give;
        exp_stall = !(give && !is_load);
        if (give) begin
          gave_gnt = 1;
          done     = !is_load;
        end else if (elapsed == T - 1) begin
          timed_out = 1;
          done      = 1;
        end
      end else begin
        n_checks++;
        if (dmem_req !== 1'b0) begin
          n_fail++;
          $display("[TB] FAIL %s resp req c%0d: req=%b, want 0", name, elapsed, dmem_req);
        end
        give        = (elapsed == gnt_wait + 1 + rv_wait);
        dmem_rvalid = give;
        dmem_rdata  = give ? rdata : $urandom;
        if (give) done = 1;
        else if (elapsed == T - 1) begin
          timed_out = 1;
          done      = 1;
        end
        exp_stall = !done;
      end
      #1;
      n_checks++;
      if (stall !== exp_stall) begin
        n_fail++;
        $display("[TB] FAIL %s stall c%0d: got %b, want %b", name, elapsed, stall, exp_stall);
      end
      @(negedge clock);
      dmem_gnt    = 1'b0;
      dmem_rvalid = 1'b0;
      elapsed++;
    end
    valid_mem = 1'b0;
    n_checks++;
    if (wb_valid !== is_load || mem_err !== timed_out || dmem_req !== 1'b0 ||
        (is_load && wb_data !== (timed_out ? 32'h0 : exp_wb))) begin
      n_fail++;
      $display("[TB] FAIL %s result: wb_valid=%b mem_err=%b req=%b wb_data=%h, want wb_valid=%b mem_err=%b req=0 wb_data=%h",
               name, wb_valid, mem_err, dmem_req, wb_data, is_load, timed_out,
               timed_out ? 32'h0 : exp_wb);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clock);
    n_checks++;
    if ({stall, wb_valid, mem_err, dmem_req, dmem_we, dmem_be} !== 9'h0 ||
        {wb_data, dmem_addr, dmem_wdata} !== 96'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_state: stall=%b wbv=%b err=%b req=%b we=%b be=%b wb=%h addr=%h wd=%h, want all 0",
               stall, wb_valid, mem_err, dmem_req, dmem_we, dmem_be, wb_data, dmem_addr, dmem_wdata);
    end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_passthrough();
    logic [5:0]  op;
    logic [31:0] val;
    for (int i = 0; i < 6; i++) begin
      if (i == 0) begin
        op  = 6'b000000;
        val = 32'h0000_1234;
      end else begin
        do op = 6'($urandom); while (is_mem(op));
        val = $urandom;
      end
      valid_mem  = 1'b1;
      insn       = {op, 26'($urandom)};
      alu_result = val;
      store_data = $urandom;
      #1;
      n_checks++;
      if (stall !== 1'b0 || dmem_req !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL passthru_%0d issue: stall=%b req=%b, want 0 0", i, stall, dmem_req);
      end
      @(negedge clock);
      valid_mem = 1'b0;
      n_checks++;
      if (wb_valid !== 1'b1 || wb_data !== val || mem_err !== 1'b0 || dmem_req !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL passthru_%0d: wbv=%b wb=%h err=%b req=%b, want 1 %h 0 0",
                 i, wb_valid, wb_data, mem_err, dmem_req, val);
      end
      @(negedge clock);
      n_checks++;
      if (wb_valid !== 1'b0 || dmem_req !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL passthru_%0d pulse: wbv=%b req=%b, want 0 0", i, wb_valid, dmem_req);
      end
    end
  endtask

  task automatic test_load_word();
    run_access(LW, 32'h0000_0100, 32'h0, 32'hCAFE_F00D, 2, 2, "lw_0x100");
    for (int i = 0; i < 4; i++)
      run_access(LW, $urandom & 32'hFFFF_FFFC, $urandom, $urandom,
                 $urandom_range(0, 5), $urandom_range(0, 5), "lw_rand");
  endtask

  task automatic test_load_byte();
    run_access(LB,  32'h0000_0103, 32'h0, 32'h0000_00F0, 1, 0, "lb_0x103");
    run_access(LBU, 32'h0000_0103, 32'h0, 32'h0000_00F0, 0, 1, "lbu_0x103");
    for (int i = 0; i < 8; i++)
      run_access((i % 2 == 0) ? LB : LBU, $urandom, $urandom, $urandom,
                 $urandom_range(0, 4), $urandom_range(0, 4), "lb_rand");
  endtask

  task automatic test_store();
    run_access(SB, 32'h0000_0101, 32'h0000_00AB, 32'h0, 0, 0, "sb_0x101");
    for (int i = 0; i < 6; i++)
      run_access((i % 2 == 0) ? SB : SW, (i % 2 == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC),
                 $urandom, 32'h0, $urandom_range(0, 5), 0, "st_rand");
  endtask

  task automatic test_misaligned();
    logic [5:0]  op;
    logic [31:0] addr;
    for (int i = 0; i < 4; i++) begin
      op   = (i % 2 == 0) ? LW : SW;
      addr = (i == 0) ? 32'h0000_0102 : (($urandom & 32'hFFFF_FFFC) | 32'($urandom_range(1, 3)));
      valid_mem  = 1'b1;
      insn       = {op, 26'($urandom)};
      alu_result = addr;
      store_data = $urandom;
      #1;
      n_checks++;
      if (stall !== 1'b0 || dmem_req !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL misalign_%0d issue: stall=%b req=%b, want 0 0", i, stall, dmem_req);
      end
      @(negedge clock);
      valid_mem = 1'b0;
      n_checks++;
      if (mem_err !== 1'b1 || wb_valid !== (op == LW) || (op == LW && wb_data !== 32'h0) ||
          dmem_req !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL misalign_%0d: err=%b wbv=%b wb=%h req=%b, want 1 %b 0 0",
                 i, mem_err, wb_valid, wb_data, dmem_req, op == LW);
      end
      @(negedge clock);
      n_checks++;
      if (mem_err !== 1'b0 || wb_valid !== 1'b0) begin
        n_fail++;
        $display("[TB] FAIL misalign_%0d pulse: err=%b wbv=%b, want 0 0", i, mem_err, wb_valid);
      end
    end
  endtask

  task automatic test_timeout();
    run_access(LW,  32'h0000_0200, 32'h0, 32'h1111_2222, 1000, 0,    "lw_no_gnt");
    run_access(SW,  32'h0000_0204, 32'h5A5A_A5A5, 32'h0, 1000, 0,    "sw_no_gnt");
    run_access(LBU, 32'h0000_0209, 32'h0, 32'h3333_4444, 5,    1000, "lbu_no_rvalid");
    run_access(LW,  32'h0000_020C, 32'h0, 32'h5555_6666, T - 1, 2,   "gnt_at_timeout");
    run_access(SB,  32'h0000_0212, 32'h0000_0077, 32'h0, T - 1, 0,   "sb_gnt_at_timeout");
    run_access(LB,  32'h0000_0216, 32'h0, 32'h7788_99AA, 10, T - 12, "rvalid_at_timeout");
  endtask

  task automatic test_back_to_back();
    logic [5:0]  op;
    logic [31:0] addr;
    for (int i = 0; i < 10; i++) begin
      op   = mem_ops[$urandom_range(0, 4)];
      addr = $urandom;
      if (op == LW || op == SW) addr = addr & 32'hFFFF_FFFC;
      run_access(op, addr, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3), "b2b");
    end
  endtask

  task automatic test_reset_mid_access();
    valid_mem  = 1'b1;
    insn       = {LW, 26'h0};
    alu_result = 32'h0000_0300;
    store_data = 32'h0;
    @(negedge clock);
    dmem_gnt = 1'b1;
    @(negedge clock);
    dmem_gnt  = 1'b0;
    reset     = 1'b1;
    valid_mem = 1'b0;
    #1;
    n_checks++;
    if ({stall, wb_valid, mem_err, dmem_req, dmem_we, dmem_be} !== 9'h0 ||
        {wb_data, dmem_addr, dmem_wdata} !== 96'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_in_resp: stall=%b wbv=%b err=%b req=%b be=%b wb=%h addr=%h, want all 0",
               stall, wb_valid, mem_err, dmem_req, dmem_be, wb_data, dmem_addr);
    end
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'hDEAD_BEEF;
    @(negedge clock);
    dmem_rvalid = 1'b0;
    n_checks++;
    if (wb_valid !== 1'b0 || mem_err !== 1'b0 || stall !== 1'b0 || dmem_req !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL late_rvalid: wbv=%b err=%b stall=%b req=%b, want all 0",
               wb_valid, mem_err, stall, dmem_req);
    end
    run_access(LW, 32'h0000_0304, 32'h0, 32'h0BAD_CAFE, 1, 1, "lw_after_reset");
  endtask

  initial begin
    reset       = 1'b1;
    valid_mem   = 1'b0;
    insn        = '0;
    alu_result  = '0;
    store_data  = '0;
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    dmem_rdata  = '0;
    test_reset();
    test_passthrough();
    test_load_word();
    test_load_byte();
    test_store();
    test_misaligned();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
